// File: rtl/cbx_param_ccff.sv
// cbx_param_ccff: parametrised horizontal connection block.
//  - CHAN_W tracks pass straight through in both directions, purely combinational.
//  - NUM_IPIN grid pins, each driven by a MUX_SIZE-tap mux. Select code 0 and
//    codes above MUX_SIZE both mean "off", which drives the pin to 0.
//  - Select bits are held in a serial config chain (ccff). A saturating shift
//    counter raises cfg_done once TOTAL_BITS bits have been shifted in since reset.
// Optional build macro: CBX_SHADOW_CFG_EN
//  - When defined, the muxes read a shadow copy of the chain. The shadow copy is
//    updated only on config_commit, so the pins do not glitch while programming.
//  - When undefined, the muxes read the chain directly and config_commit is ignored.
// Parameter legality: MUX_SIZE must be even and lie in 2..2*CHAN_W.

// Per-pin mux decode. tap_i already holds the MUX_SIZE candidate track bits.
module cbx_param_ccff_pin #(
  parameter int MUX_SIZE = 10,
  parameter int SEL_W    = $clog2(MUX_SIZE + 1)
) (
  input  logic [SEL_W-1:0]    sel_i,
  input  logic [MUX_SIZE-1:0] tap_i,
  output logic                ipin_o
);

  // Code k in 1..MUX_SIZE picks tap k-1. Code 0 and out-of-range codes give 0.
  always_comb begin
    ipin_o = 1'b0;
    for (int j = 0; j < MUX_SIZE; j++) begin
      if (sel_i == SEL_W'(j + 1)) ipin_o = tap_i[j];
    end
  end

endmodule

module cbx_param_ccff #(
  parameter int CHAN_W     = 20,
  parameter int NUM_IPIN   = 9,
  parameter int MUX_SIZE   = 10,
  parameter int TAP_STRIDE = 4
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              config_enable,
  input  logic              ccff_head,
  input  logic              config_commit,
  input  logic [CHAN_W-1:0] chanx_left_in,
  input  logic [CHAN_W-1:0] chanx_right_in,
  output logic [CHAN_W-1:0] chanx_left_out,
  output logic [CHAN_W-1:0] chanx_right_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic              ccff_tail,
  output logic              cfg_done
);

  localparam int SEL_W      = $clog2(MUX_SIZE + 1);
  localparam int TOTAL_BITS = NUM_IPIN * SEL_W;
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

  // Chain storage: bit i of cfg_q is chain position i; position 0 is nearest the head.
  logic [TOTAL_BITS-1:0] cfg_q, cfg_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [TOTAL_BITS-1:0] act;

  // Channel pass-through: the output on each side carries the track from the opposite side.
  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  // Shift the chain one place toward the tail on each enabled edge.
  // The counter saturates at TOTAL_BITS, so cfg_done stays high while reloading.
  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    if (config_enable) begin
      cfg_d = {cfg_q[TOTAL_BITS-2:0], ccff_head};
      if (cnt_q != CNT_W'(TOTAL_BITS)) cnt_d = cnt_q + CNT_W'(1);
    end
    done_d = (cnt_d == CNT_W'(TOTAL_BITS));
  end

  // Chain, counter and done flag. All of them clear asynchronously on reset.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cfg_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign ccff_tail = cfg_q[TOTAL_BITS-1];
  assign cfg_done  = done_q;

`ifdef CBX_SHADOW_CFG_EN
  logic [TOTAL_BITS-1:0] act_q;

  // Shadow copy of the chain. On a commit edge it samples the value from before the shift.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset)             act_q <= '0;
    else if (config_commit) act_q <= cfg_q;
  end

  assign act = act_q;
`else
  logic unused_commit;
  assign unused_commit = config_commit;
  assign act = cfg_q;
`endif

  // Tap wiring: tap j of pin p reads track (p + (j/2)*TAP_STRIDE) mod CHAN_W.
  // Even taps read the left-side input; odd taps read the right-side input.
  logic [NUM_IPIN-1:0][MUX_SIZE-1:0] taps;

  for (genvar p = 0; p < NUM_IPIN; p++) begin : g_pin
    for (genvar j = 0; j < MUX_SIZE; j++) begin : g_tap
      localparam int T = (p + (j / 2) * TAP_STRIDE) % CHAN_W;
      if (j % 2 == 0) begin : g_l
        assign taps[p][j] = chanx_left_in[T];
      end else begin : g_r
        assign taps[p][j] = chanx_right_in[T];
      end
    end

    cbx_param_ccff_pin #(
      .MUX_SIZE (MUX_SIZE),
      .SEL_W    (SEL_W)
    ) u_pin (
      .sel_i  (act[p*SEL_W +: SEL_W]),
      .tap_i  (taps[p]),
      .ipin_o (ipin_out[p])
    );
  end

endmodule

// File: doc/cbx_param_ccff.md
Name: cbx_param_ccff

Overview:
- Parametrised horizontal connection block. It carries CHAN_W tracks straight through in both directions.
- It drives NUM_IPIN grid input pins, each through a MUX_SIZE-input routing mux with a dedicated "off" code.
- The select bits live in an integrated configuration-chain shift register (ccff). A shift counter reports when the chain is fully loaded.
- It is the next-generation replacement for the fixed-size cbx tiles: width, pin count and mux size are generic.

Parameters:
- CHAN_W, 20, tracks per direction.
- NUM_IPIN, 9, grid input pins driven.
- MUX_SIZE, 10, taps per pin mux. Must be even and 2..2*CHAN_W.
- TAP_STRIDE, 4, track spacing between successive tap pairs.
- SEL_W (localparam), $clog2(MUX_SIZE+1), select bits per pin.
- TOTAL_BITS (localparam), NUM_IPIN*SEL_W, chain length.

Ports:
- prog_clk, in, 1: configuration clock; single clock domain.
- pReset, in, 1: reset, asynchronous, active-high.
- config_enable, in, 1: shift enable for the chain.
- ccff_head, in, 1: chain serial input.
- config_commit, in, 1: shadow commit strobe. Ignored unless CBX_SHADOW_CFG_EN is defined.
- chanx_left_in, in, CHAN_W: tracks arriving from the left.
- chanx_right_in, in, CHAN_W: tracks arriving from the right.
- chanx_left_out, out, CHAN_W: equals chanx_right_in.
- chanx_right_out, out, CHAN_W: equals chanx_left_in.
- ipin_out, out, NUM_IPIN: grid pin drives.
- ccff_tail, out, 1: chain serial output.
- cfg_done, out, 1: chain fully loaded since reset.

Behaviour:
- Pass-through: both chanx_*_out assignments are purely combinational, with no registers.
- Chain register cfg[0:TOTAL_BITS-1]. On a prog_clk rising edge with config_enable=1:
  - cfg[0] <= ccff_head;
  - cfg[i] <= cfg[i-1] for i = 1..TOTAL_BITS-1.
- With config_enable=0 the chain holds.
- ccff_tail = cfg[TOTAL_BITS-1], a registered bit. Serial latency head to tail is exactly TOTAL_BITS enabled edges.
- Active select for pin p: sel_p = act[p*SEL_W +: SEL_W], with the LSB at the lower index.
  - Without the macro, act = cfg.
  - Consequence: the last bit shifted lands in pin 0's LSB; the first bit shifted ends in pin NUM_IPIN-1's MSB.
- Mux decode for pin p:
  - sel_p = 0 gives ipin_out[p] = 0 (off).
  - sel_p = k with 1 <= k <= MUX_SIZE selects tap k-1.
  - sel_p > MUX_SIZE gives 0.
  - The decode is combinational from act and the channel inputs.
- Tap j of pin p: track t = (p + (j>>1)*TAP_STRIDE) mod CHAN_W. Even j selects chanx_left_in[t]; odd j selects chanx_right_in[t].
- Shift counter cnt, width $clog2(TOTAL_BITS+1):
  - increments on each enabled shift;
  - saturates at TOTAL_BITS and never wraps;
  - cfg_done = (cnt == TOTAL_BITS), registered. It stays high through any further shifting.
- pReset (asynchronous assert, released synchronously by the environment) clears cfg, act, cnt, ccff_tail and cfg_done to 0. As a result every ipin_out = 0 during and after reset.
- Reset during a shift sequence: all state returns to 0 immediately and the partial load is discarded.
- A second load after cfg_done: shifting simply continues and cfg_done remains 1. Only pReset clears cfg_done.

Optional Feature:
- Macro: CBX_SHADOW_CFG_EN.
- Defined:
  - act is a separate shadow register of TOTAL_BITS.
  - On a prog_clk edge with config_commit=1, act <= cfg. When config_enable is also 1 on that edge, act takes the pre-shift cfg value.
  - ipin_out therefore changes only on commit, so there is no glitching on pin muxes while programming.
  - act resets to 0.
- Undefined: act = cfg directly, muxes follow the chain live, and config_commit has no effect.

Test Plan (defaults: TOTAL_BITS=36, SEL_W=4):
- Reset then idle:
  - drive chanx_left_in=20'hFFFFF, chanx_right_in=20'h0 -> ipin_out=9'h000, cfg_done=0, ccff_tail=0;
  - chanx_right_out=20'hFFFFF, chanx_left_out=20'h0.
- Shift 35 zeros then a 1 (36 enabled edges) -> cfg_done rises on edge 36 (0 after edge 35); pin 0 sel=1 (tap 0); ipin_out[0] follows chanx_left_in[0]; other pins 0. Macro builds: only after a config_commit pulse.
- Load pin 8 sel=10 (first 4 bits shifted 1,0,1,0, then 32 zeros) -> pin 8 selects tap 9, i.e. chanx_right_in[4]. Toggling that bit alone toggles ipin_out[8].
- Load any pin with sel=15 -> ipin_out[p]=0 regardless of channel inputs.
- Shift a 1 followed by zeros with config_enable toggling every other cycle -> ccff_tail goes 1 exactly after the 36th enabled edge. Disabled edges do not advance it.
- Assert pReset after 20 enabled shifts -> cfg, cnt, cfg_done and ipin_out all 0 immediately. A full 36-bit reload is then required for cfg_done=1.
